// File: rtl/trap_sequencer.sv
// trap_sequencer
// Purpose:
//   Sequences the response to a trap request from the exception handling unit,
//   and the response to an MRET.
//   On a trap it does four things in order:
//     1. flushes the pipeline for one cycle, with the pipeline stalled,
//     2. writes mepc, mcause and mtval through the single CSR write port,
//     3. offers MTVEC as the new fetch PC,
//     4. returns to IDLE once fetch accepts that PC.
//   An MRET flushes for one cycle and then offers the captured mepc as the new
//   fetch PC.
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   initiate_illinst    illegal-instruction trap request (mcause 2)
//   initiate_misaligned misaligned-access trap request; misalign_kind selects the cause
//   exc_pc, exc_tval    faulting PC and trap value, captured when the trap is accepted
//   mret, mepc_in       MRET commit and current mepc, captured when the MRET is accepted
//   flush, stall        pipeline control
//   csr_we/addr/wdata   CSR file write port
//   redirect_valid/pc   new fetch PC offer; redirect_ready is the fetch-side accept
//   busy                high whenever a sequence is in progress
module trap_sequencer #(
  parameter logic [31:0] MTVEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        initiate_illinst,
  input  logic        initiate_misaligned,
  input  logic [1:0]  misalign_kind,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret,
  input  logic [31:0] mepc_in,
  output logic        flush,
  output logic        stall,
  output logic        csr_we,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        busy
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] FLUSH    = 3'd1;
  localparam logic [2:0] W_MEPC   = 3'd2;
  localparam logic [2:0] W_MCAUSE = 3'd3;
  localparam logic [2:0] W_MTVAL  = 3'd4;
  localparam logic [2:0] RFLUSH   = 3'd5;
  localparam logic [2:0] REDIRECT = 3'd6;

  localparam logic [11:0] ADDR_MEPC   = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE = 12'h342;
  localparam logic [11:0] ADDR_MTVAL  = 12'h343;

  logic [2:0]  state;
  logic [2:0]  next_state;
  logic [31:0] cap_pc;
  logic [31:0] cap_tval;
  logic [3:0]  cap_cause;
  logic [31:0] target;
  logic        trap;
  logic [3:0]  trap_cause;

  assign trap = initiate_illinst | initiate_misaligned;

  // Illegal instruction has priority over a misaligned access.
  // The reserved misalign kind is reported with the store cause.
  always_comb begin
    trap_cause = 4'd2;
    if (!initiate_illinst) begin
      case (misalign_kind)
        2'd0:    trap_cause = 4'd0;
        2'd1:    trap_cause = 4'd4;
        default: trap_cause = 4'd6;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (trap)
          next_state = FLUSH;
        else if (mret)
          next_state = RFLUSH;
      end
      FLUSH:    next_state = W_MEPC;
      W_MEPC:   next_state = W_MCAUSE;
      W_MCAUSE: next_state = W_MTVAL;
      W_MTVAL:  next_state = REDIRECT;
      RFLUSH:   next_state = REDIRECT;
      REDIRECT: if (redirect_ready) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Capture registers are only loaded when a request is accepted in IDLE.
  // Because of that, requests arriving mid-sequence leave the sequence untouched.
  // The trap target is loaded late, in W_MTVAL, so one register serves both
  // the trap redirect and the MRET redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cap_pc    <= 32'h0;
      cap_tval  <= 32'h0;
      cap_cause <= 4'h0;
      target    <= 32'h0;
    end else begin
      state <= next_state;
      if (state == IDLE) begin
        if (trap) begin
          cap_pc    <= exc_pc;
          cap_tval  <= exc_tval;
          cap_cause <= trap_cause;
        end else if (mret) begin
          target <= mepc_in;
        end
      end
      if (state == W_MTVAL)
        target <= MTVEC & ~32'h3;
    end
  end

  // Outputs decode only from registered state and the capture registers.
  // Data outputs read zero outside the states that drive them.
  always_comb begin
    flush          = 1'b0;
    stall          = (state != IDLE);
    busy           = (state != IDLE);
    csr_we         = 1'b0;
    csr_addr       = 12'h0;
    csr_wdata      = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    case (state)
      FLUSH, RFLUSH: flush = 1'b1;
      W_MEPC: begin
        csr_we    = 1'b1;
        csr_addr  = ADDR_MEPC;
        csr_wdata = {cap_pc[31:2], 2'b00};
      end
      W_MCAUSE: begin
        csr_we    = 1'b1;
        csr_addr  = ADDR_MCAUSE;
        csr_wdata = {28'h0, cap_cause};
      end
      W_MTVAL: begin
        csr_we    = 1'b1;
        csr_addr  = ADDR_MTVAL;
        csr_wdata = cap_tval;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = target;
      end
      default: ;
    endcase
  end

endmodule
